// File: rtl/omsp_spm_cmd_sched_pkg.sv
// omsp_spm_cmd_sched_pkg: SPM command/status codes and scheduler state encoding.
package omsp_spm_cmd_sched_pkg;
    localparam logic [1:0] SPM_OP_ILLEGAL   = 2'b00;
    localparam logic [1:0] SPM_OP_PROTECT   = 2'b01;
    localparam logic [1:0] SPM_OP_UNPROTECT = 2'b10;
    localparam logic [1:0] SPM_OP_QUERY     = 2'b11;
    localparam logic [1:0] SPM_ST_OK        = 2'b00;
    localparam logic [1:0] SPM_ST_VIOLATION = 2'b01;
    localparam logic [1:0] SPM_ST_NO_MATCH  = 2'b10;
    localparam logic [1:0] SPM_ST_BAD_OP    = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_QUERY, ST_RESP} state_e;
    function automatic int id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/omsp_spm_rr_arbiter.sv
// omsp_spm_rr_arbiter: round-robin pick of the first valid requester at/after the pointer;
// the pointer moves just past the winner on accept.
module omsp_spm_rr_arbiter
    import omsp_spm_cmd_sched_pkg::*;
#(
    parameter int NB_REQ = 2,
    localparam int IDW = id_w(NB_REQ)
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic [NB_REQ-1:0] req,
    input  logic              accept,
    output logic [NB_REQ-1:0] gnt,
    output logic [IDW-1:0]    id
);
    logic [IDW-1:0] ptr_q, ptr_d, idx;
    logic           found;

    always_comb begin
        gnt   = '0;
        id    = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NB_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
        ptr_d = accept ? IDW'((int'(id) + 1) % NB_REQ) : ptr_q;
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end
endmodule

// File: rtl/omsp_spm_cmd_sched.sv
// omsp_spm_cmd_sched: arbitrates SPM protect/unprotect/query commands onto the single
// omsp_spm_control port and returns status/data to the granted requester.
module omsp_spm_cmd_sched
    import omsp_spm_cmd_sched_pkg::*;
#(
    parameter int NB_REQ = 2,
    parameter int DREQ_W = 3,
    localparam int IDW = id_w(NB_REQ)
) (
    input  logic                     mclk,
    input  logic                     puc_rst_n,
    input  logic [NB_REQ-1:0]        req_valid,
    output logic [NB_REQ-1:0]        req_ready,
    input  logic [2*NB_REQ-1:0]      req_op,
    input  logic [16*NB_REQ-1:0]     req_r12,
    input  logic [16*NB_REQ-1:0]     req_r13,
    input  logic [16*NB_REQ-1:0]     req_r14,
    input  logic [16*NB_REQ-1:0]     req_r15,
    input  logic [DREQ_W*NB_REQ-1:0] req_dreq,
    output logic [NB_REQ-1:0]        rsp_valid,
    input  logic [NB_REQ-1:0]        rsp_ready,
    output logic [1:0]               rsp_status,
    output logic [15:0]              rsp_data,
    output logic                     spm_update,
    output logic                     spm_enable,
    output logic [15:0]              spm_r12,
    output logic [15:0]              spm_r13,
    output logic [15:0]              spm_r14,
    output logic [15:0]              spm_r15,
    output logic [DREQ_W-1:0]        spm_data_request,
    input  logic                     spm_violation,
    input  logic                     spm_select_valid,
    input  logic [15:0]              spm_requested_data,
    output logic                     busy,
    output logic                     viol_sticky,
    input  logic                     viol_clr,
    output logic [15:0]              cmd_count
);
    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d, status_q, status_d;
    logic [15:0]         r_q [4];
    logic [15:0]         r_d [4];
    logic [DREQ_W-1:0]   dreq_q, dreq_d;
    logic [IDW-1:0]      id_q, id_d, gnt_id;
    logic [15:0]         data_q, data_d, cnt_q, cnt_d;
    logic                viol_q, viol_d, accept, hit, drv;
    logic [NB_REQ-1:0]   gnt;
    logic [1:0]          op_a   [NB_REQ];
    logic [15:0]         r12_a  [NB_REQ];
    logic [15:0]         r13_a  [NB_REQ];
    logic [15:0]         r14_a  [NB_REQ];
    logic [15:0]         r15_a  [NB_REQ];
    logic [DREQ_W-1:0]   dreq_a [NB_REQ];

    for (genvar i = 0; i < NB_REQ; i++) begin : g_slice
        assign op_a[i]   = req_op[2*i +: 2];
        assign r12_a[i]  = req_r12[16*i +: 16];
        assign r13_a[i]  = req_r13[16*i +: 16];
        assign r14_a[i]  = req_r14[16*i +: 16];
        assign r15_a[i]  = req_r15[16*i +: 16];
        assign dreq_a[i] = req_dreq[DREQ_W*i +: DREQ_W];
    end

    omsp_spm_rr_arbiter #(.NB_REQ(NB_REQ)) u_arb (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .req       (req_valid),
        .accept    (accept),
        .gnt       (gnt),
        .id        (gnt_id)
    );

    assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);
    assign hit       = (dreq_q != '0) && spm_select_valid;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        r_d      = r_q;
        dreq_d   = dreq_q;
        id_d     = id_q;
        status_d = status_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        viol_d   = (state_q == ST_ISSUE && spm_violation) ? 1'b1 : viol_clr ? 1'b0 : viol_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d     = op_a[gnt_id];
                r_d      = '{r12_a[gnt_id], r13_a[gnt_id], r14_a[gnt_id], r15_a[gnt_id]};
                dreq_d   = dreq_a[gnt_id];
                id_d     = gnt_id;
                status_d = SPM_ST_BAD_OP;
                data_d   = '0;
                state_d  = (op_d == SPM_OP_PROTECT || op_d == SPM_OP_UNPROTECT) ? ST_ISSUE :
                           (op_d == SPM_OP_QUERY) ? ST_QUERY : ST_RESP;
            end
            ST_ISSUE: begin
                status_d = spm_violation ? SPM_ST_VIOLATION : SPM_ST_OK;
                state_d  = ST_RESP;
            end
            ST_QUERY: begin
                status_d = hit ? SPM_ST_OK : SPM_ST_NO_MATCH;
                data_d   = hit ? spm_requested_data : '0;
                state_d  = ST_RESP;
            end
            default: if (rsp_ready[id_q]) begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q + 16'd1;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= SPM_OP_ILLEGAL;
            r_q      <= '{default: '0};
            dreq_q   <= '0;
            id_q     <= '0;
            status_q <= SPM_ST_OK;
            data_q   <= '0;
            cnt_q    <= '0;
            viol_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            r_q      <= r_d;
            dreq_q   <= dreq_d;
            id_q     <= id_d;
            status_q <= status_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            viol_q   <= viol_d;
        end
    end

    // Control-side outputs decode only from registered state, never from req_* inputs.
    assign drv              = (state_q == ST_ISSUE) || (state_q == ST_QUERY);
    assign spm_update       = (state_q == ST_ISSUE);
    assign spm_enable       = (state_q == ST_ISSUE) && (op_q == SPM_OP_PROTECT);
    assign spm_data_request = (state_q == ST_QUERY) ? dreq_q : '0;
    assign spm_r12          = drv ? r_q[0] : '0;
    assign spm_r13          = drv ? r_q[1] : '0;
    assign spm_r14          = drv ? r_q[2] : '0;
    assign spm_r15          = drv ? r_q[3] : '0;
    assign rsp_valid        = (state_q == ST_RESP) ? NB_REQ'(1) << id_q : '0;
    assign rsp_status       = (state_q == ST_RESP) ? status_q : '0;
    assign rsp_data         = (state_q == ST_RESP) ? data_q : '0;
    assign busy             = (state_q != ST_IDLE);
    assign viol_sticky      = viol_q;
    assign cmd_count        = cnt_q;
endmodule

// File: tb/tb_omsp_spm_cmd_sched.sv
// tb_omsp_spm_cmd_sched: directed table, corner sequences and randomized commands
// checked against a command-level reference model.
module tb_omsp_spm_cmd_sched;
    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_status;
    logic [3:0]  req_op = '0;
    logic [31:0] req_r12 = '0, req_r13 = '0, req_r14 = '0, req_r15 = '0;
    logic [5:0]  req_dreq = '0;
    logic [15:0] rsp_data, spm_r12, spm_r13, spm_r14, spm_r15, spm_requested_data = '0, cmd_count;
    logic        spm_update, spm_enable, spm_violation = 1'b0, spm_select_valid = 1'b0;
    logic        busy, viol_sticky, viol_clr = 1'b0;
    logic [2:0]  spm_data_request;
    logic [12:0] sm;
    logic [63:0] big;
    int          n_chk = 0, n_pass = 0;
    int          exp_cnt = 0;
    logic        exp_viol = 1'b0;

    always #5 mclk = ~mclk;

    omsp_spm_cmd_sched dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_r12(req_r12), .req_r13(req_r13), .req_r14(req_r14), .req_r15(req_r15),
        .req_dreq(req_dreq), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .spm_update(spm_update), .spm_enable(spm_enable),
        .spm_r12(spm_r12), .spm_r13(spm_r13), .spm_r14(spm_r14), .spm_r15(spm_r15),
        .spm_data_request(spm_data_request), .spm_violation(spm_violation),
        .spm_select_valid(spm_select_valid), .spm_requested_data(spm_requested_data),
        .busy(busy), .viol_sticky(viol_sticky), .viol_clr(viol_clr), .cmd_count(cmd_count)
    );

    assign sm  = {req_ready, rsp_valid, rsp_status, spm_update, spm_enable,
                  spm_data_request, busy, viol_sticky};
    assign big = {rsp_data, spm_r12, spm_r15, cmd_count};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Outcome of one command from the op/control-answer rules: {status, data}.
    function automatic logic [17:0] ref_rsp(input logic [1:0] op, input logic [2:0] dq,
                                            input logic v, input logic sv, input logic [15:0] rd);
        if (op == 2'b00) return {2'b11, 16'h0};
        if (op != 2'b11) return {(v ? 2'b01 : 2'b00), 16'h0};
        return (dq != 3'd0 && sv) ? {2'b00, rd} : {2'b10, 16'h0};
    endfunction

    // Runs one command from a single requester; starts and ends at a negedge with the DUT idle.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [15:0] b,
                          input logic [2:0] dq, input logic v, input logic sv,
                          input logic [15:0] rd, input logic clr,
                          input logic [1:0] es, input logic [15:0] ed);
        logic [1:0] one;
        one = 2'(1 << id);
        req_valid = one;
        req_op = '0;    req_op[2*id +: 2] = op;
        req_r12 = '0;   req_r12[16*id +: 16] = b;
        req_r13 = '0;   req_r13[16*id +: 16] = b + 16'd1;
        req_r14 = '0;   req_r14[16*id +: 16] = b + 16'd2;
        req_r15 = '0;   req_r15[16*id +: 16] = b + 16'd3;
        req_dreq = '0;  req_dreq[3*id +: 3] = dq;
        spm_violation = v; spm_select_valid = sv; spm_requested_data = rd;
        #1;
        chk("ready", req_ready, one);
        chk("idle_busy", busy, 0);
        @(negedge mclk);
        req_valid = '0;
        req_op = 4'($urandom);
        req_r12 = $urandom; req_r15 = $urandom; req_dreq = 6'($urandom);
        viol_clr = clr;
        if (op == 2'b00) begin
            chk("bad_rsp", rsp_valid, one);
            chk("bad_upd", spm_update, 0);
            chk("bad_dr", spm_data_request, 0);
        end else begin
            chk("upd", spm_update, op != 2'b11);
            chk("en", spm_enable, op == 2'b01);
            chk("dr", spm_data_request, op == 2'b11 ? dq : 3'd0);
            chk("r12", spm_r12, b);
            chk("r15", spm_r15, b + 16'd3);
            chk("busy_ready", {busy, req_ready}, 3'b100);
            @(negedge mclk);
            viol_clr = 1'b0;
            chk("upd_off", {spm_update, spm_data_request}, 0);
        end
        chk("rsp_v", rsp_valid, one);
        chk("rsp_st", rsp_status, es);
        chk("rsp_d", rsp_data, ed);
        rsp_ready = ~one;
        @(negedge mclk);
        viol_clr = 1'b0;
        chk("rsp_hold", {rsp_valid, rsp_status, rsp_data, spm_update, spm_data_request},
            {one, es, ed, 4'h0});
        rsp_ready = one;
        @(negedge mclk);
        rsp_ready = '0;
        exp_cnt++;
        if ((op == 2'b01 || op == 2'b10) && v) exp_viol = 1'b1;
        else if (clr) exp_viol = 1'b0;
        chk("done", {busy, rsp_valid}, 0);
        chk("count", cmd_count, 16'(exp_cnt));
        chk("sticky", viol_sticky, exp_viol);
    endtask

    task automatic finish_rsp(input int id);
        int n = 0;
        while (rsp_valid[id] !== 1'b1 && n < 6) begin
            @(negedge mclk);
            n++;
        end
        chk("rsp_wait", rsp_valid[id], 1);
        rsp_ready = 2'(1 << id);
        @(negedge mclk);
        rsp_ready = '0;
        exp_cnt++;
    endtask

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [15:0] b;
        logic [2:0]  dq;
        logic        v, sv;
        logic [15:0] rd;
        logic        clr;
        logic [1:0]  es;
        logic [15:0] ed;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 2'b01, 16'h1000, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000};
        tbl[1] = '{1, 2'b11, 16'h2000, 3'd2, 1'b0, 1'b1, 16'hBEEF, 1'b0, 2'b00, 16'hBEEF};
        tbl[2] = '{1, 2'b11, 16'h2100, 3'd2, 1'b0, 1'b0, 16'hBEEF, 1'b0, 2'b10, 16'h0000};
        tbl[3] = '{0, 2'b01, 16'h3000, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b01, 16'h0000};
        tbl[4] = '{0, 2'b01, 16'h3100, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 16'h0000};
        tbl[5] = '{1, 2'b00, 16'h4000, 3'd5, 1'b1, 1'b1, 16'h5555, 1'b1, 2'b11, 16'h0000};
        tbl[6] = '{0, 2'b11, 16'h5000, 3'd0, 1'b0, 1'b1, 16'h1234, 1'b0, 2'b10, 16'h0000};
        tbl[7] = '{1, 2'b10, 16'h6000, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 16'h0000};
        tbl[8] = '{0, 2'b10, 16'h7000, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b01, 16'h0000};
        tbl[9] = '{1, 2'b11, 16'hFFF0, 3'd7, 1'b0, 1'b1, 16'hA5A5, 1'b0, 2'b00, 16'hA5A5};

        repeat (2) @(negedge mclk);
        chk("reset_sm", sm, 0);
        chk("reset_big", big, 0);
        puc_rst_n = 1'b1;
        @(negedge mclk);

        foreach (tbl[i])
            do_cmd(tbl[i].id, tbl[i].op, tbl[i].b, tbl[i].dq, tbl[i].v, tbl[i].sv,
                   tbl[i].rd, tbl[i].clr, tbl[i].es, tbl[i].ed);

        viol_clr = 1'b1;
        @(negedge mclk);
        viol_clr = 1'b0;
        exp_viol = 1'b0;
        chk("clr_idle", viol_sticky, 0);

        // Reset while the update pulse is on the control port.
        req_valid = 2'b01; req_op = 4'b0001; req_r12 = 32'h7777; req_r15 = 32'h7777;
        spm_violation = 1'b1;
        @(negedge mclk);
        req_valid = '0;
        chk("rstI_upd", spm_update, 1);
        puc_rst_n = 1'b0;
        #1;
        chk("rstI_sm", sm, 0);
        chk("rstI_big", big, 0);
        @(negedge mclk);
        chk("rstI_hold", sm, 0);
        puc_rst_n = 1'b1;
        spm_violation = 1'b0;
        exp_cnt = 0;
        exp_viol = 1'b0;
        repeat (3) begin
            @(negedge mclk);
            chk("rstI_quiet", sm, 0);
        end

        // Reset while a response waits for rsp_ready.
        req_valid = 2'b10; req_op = 4'b1000;
        @(negedge mclk);
        req_valid = '0;
        @(negedge mclk);
        chk("rstR_v", rsp_valid, 2'b10);
        puc_rst_n = 1'b0;
        #1;
        chk("rstR_sm", sm, 0);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        repeat (3) begin
            @(negedge mclk);
            chk("rstR_quiet", sm, 0);
        end
        chk("rstR_big", big, 0);

        // Round-robin with both requesters pending, pointer at 0 after reset.
        req_op = 4'b0101;
        req_valid = 2'b11;
        #1;
        chk("rr_first", req_ready, 2'b01);
        @(negedge mclk);
        req_valid = 2'b10;
        chk("rr_busy", req_ready, 2'b00);
        finish_rsp(0);
        chk("rr_next", req_ready, 2'b10);
        @(negedge mclk);
        req_valid = '0;
        finish_rsp(1);
        req_valid = 2'b11;
        #1;
        chk("rr_wrap", req_ready, 2'b01);
        @(negedge mclk);
        req_valid = '0;
        finish_rsp(0);
        req_valid = 2'b11;
        #1;
        chk("rr_dbg", req_ready, 2'b10);
        @(negedge mclk);
        req_valid = '0;
        finish_rsp(1);
        chk("rr_count", cmd_count, 16'(exp_cnt));

        for (int n = 0; n < 300; n++) begin
            int          id;
            logic [1:0]  op;
            logic [2:0]  dq;
            logic        v, sv, clr;
            logic [15:0] b, rd;
            logic [17:0] r;
            id  = int'($urandom_range(0, 1));
            op  = 2'($urandom);
            dq  = 3'($urandom);
            v   = 1'($urandom);
            sv  = 1'($urandom);
            clr = ($urandom_range(0, 3) == 0);
            b   = 16'($urandom);
            rd  = 16'($urandom);
            r   = ref_rsp(op, dq, v, sv, rd);
            do_cmd(id, op, b, dq, v, sv, rd, clr, r[17:16], r[15:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
